// File: rtl/uproc_pkg.sv
// rtl/uproc_pkg.sv - shared types and default sizes for the operand path
//
// Purpose: holds the operand register state encoding and the default
// operand width / source count used by operand_source_select and its mux.
// Ports: none (package).

package uproc_pkg;

   // Operand register occupancy: EMPTY has nothing for the ALU, FULL holds
   // one unconsumed operand.
   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } sel_state_t;

   localparam int DEF_DATA_WIDTH  = 8;
   localparam int DEF_NUM_SOURCES = 8;

endpackage

// File: rtl/source_mux_n.sv
// rtl/source_mux_n.sv - combinational N-to-1 operand source select
//
// Purpose: picks one DataWidth slice out of a flattened source bus.
// Indices with no matching source return all-zeros and drop in_range_o.
// Ports:
//   in_data_i  : NumSources*DataWidth flattened sources, source k at [k*DataWidth +: DataWidth]
//   sel_i      : source index
//   data_o     : selected source, or zero when sel_i is out of range
//   in_range_o : high when sel_i names an existing source

module source_mux_n
   import uproc_pkg::*;
#(
   parameter  int DataWidth  = DEF_DATA_WIDTH,
   parameter  int NumSources = DEF_NUM_SOURCES,
   localparam int SelWidth   = $clog2(NumSources)
) (
   input  logic [NumSources*DataWidth-1:0] in_data_i,
   input  logic [SelWidth-1:0]             sel_i,
   output logic [DataWidth-1:0]            data_o,
   output logic                            in_range_o
);

   // Compare against every legal index rather than slicing with sel_i
   // directly, so an index past the last source naturally falls through to
   // the zero default instead of reading beyond the bus.
   always_comb begin
      data_o     = '0;
      in_range_o = 1'b0;
      for (int k = 0; k < NumSources; k++) begin
         if (sel_i == SelWidth'(k)) begin
            data_o     = in_data_i[k*DataWidth +: DataWidth];
            in_range_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/operand_source_select.sv
// rtl/operand_source_select.sv - registered operand source select with valid/ready handshake
//
// Purpose: on each accepted request, registers the operand chosen by
// SelDataSource and presents it to the ALU until it is drained. Flags
// out-of-range selects (sticky) and counts accepted requests.
// Ports:
//   clk, rst_n     : clock (rising edge), asynchronous active-low reset
//   in_data        : flattened sources, source k at [k*DataWidth +: DataWidth]
//   SelDataSource  : source index for the current request
//   in_valid       : request present
//   in_ready       : request can be accepted this cycle (combinational)
//   out_data       : registered selected operand
//   out_valid      : out_data holds an unconsumed operand
//   out_ready      : consumer takes out_data this cycle
//   hold           : freeze - no accept, no drain
//   sel_err        : sticky out-of-range select flag
//   err_clr        : synchronous clear of sel_err
//   accept_cnt     : wrapping count of accepted requests

module operand_source_select
   import uproc_pkg::*;
#(
   parameter  int DataWidth  = DEF_DATA_WIDTH,
   parameter  int NumSources = DEF_NUM_SOURCES,
   localparam int SelWidth   = $clog2(NumSources)
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NumSources*DataWidth-1:0] in_data,
   input  logic [SelWidth-1:0]             SelDataSource,
   input  logic                            in_valid,
   output logic                            in_ready,
   output logic [DataWidth-1:0]            out_data,
   output logic                            out_valid,
   input  logic                            out_ready,
   input  logic                            hold,
   output logic                            sel_err,
   input  logic                            err_clr,
   output logic [7:0]                      accept_cnt
);

   sel_state_t           state_q, state_d;
   logic [DataWidth-1:0] data_q, data_d;
   logic                 err_q, err_d;
   logic [7:0]           cnt_q, cnt_d;

   logic [DataWidth-1:0] mux_data;
   logic                 mux_in_range;
   logic                 accept;
   logic                 drain;

   source_mux_n #(
      .DataWidth  (DataWidth),
      .NumSources (NumSources)
   ) u_mux (
      .in_data_i  (in_data),
      .sel_i      (SelDataSource),
      .data_o     (mux_data),
      .in_range_o (mux_in_range)
   );

   assign out_valid  = (state_q == FULL);
   assign out_data   = data_q;
   assign sel_err    = err_q;
   assign accept_cnt = cnt_q;

   // A full register can still take a new request in the same cycle it is
   // drained, giving one operand per cycle.
   assign in_ready = !hold && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;
   assign drain    = out_valid && out_ready && !hold;

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      if (accept) begin
         state_d = FULL;
         data_d  = mux_data;
         cnt_d   = cnt_q + 8'd1;
      end else if (drain) begin
         state_d = EMPTY;
      end
   end

   // A new error outranks a clear arriving in the same cycle. The clear is
   // not gated by hold.
   always_comb begin
      err_d = err_q;
      if (accept && !mux_in_range) begin
         err_d = 1'b1;
      end else if (err_clr) begin
         err_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         data_q  <= '0;
         err_q   <= 1'b0;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_operand_source_select.sv
// tb/tb_operand_source_select.sv - self-checking bench for operand_source_select

module tb_operand_source_select;

   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [8*DW-1:0] in_data;
   logic [2:0]    sel;
   logic          in_valid, out_ready, hold, err_clr;

   logic          in_ready8, out_valid8, sel_err8;
   logic          in_ready6, out_valid6, sel_err6;
   logic [7:0]    out_data8, out_data6, cnt8, cnt6;

   int checks = 0;
   int errors = 0;

   // Reference state per instance: index 0 is the 8-source DUT, 1 the 6-source DUT.
   logic       m_valid [2];
   logic [7:0] m_data  [2];
   logic       m_err   [2];
   logic [7:0] m_cnt   [2];

   always #5 clk = ~clk;

   operand_source_select #(.DataWidth(8), .NumSources(8)) u_dut8 (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_data       (in_data),
      .SelDataSource (sel),
      .in_valid      (in_valid),
      .in_ready      (in_ready8),
      .out_data      (out_data8),
      .out_valid     (out_valid8),
      .out_ready     (out_ready),
      .hold          (hold),
      .sel_err       (sel_err8),
      .err_clr       (err_clr),
      .accept_cnt    (cnt8)
   );

   operand_source_select #(.DataWidth(8), .NumSources(6)) u_dut6 (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_data       (in_data[6*DW-1:0]),
      .SelDataSource (sel),
      .in_valid      (in_valid),
      .in_ready      (in_ready6),
      .out_data      (out_data6),
      .out_valid     (out_valid6),
      .out_ready     (out_ready),
      .hold          (hold),
      .sel_err       (sel_err6),
      .err_clr       (err_clr),
      .accept_cnt    (cnt6)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] pick(input int n, input int s);
      if (s < n) return in_data[s*8 +: 8];
      return 8'h00;
   endfunction

   task automatic set_sources();
      for (int k = 0; k < 8; k++) in_data[k*8 +: 8] = 8'h10 + 8'(k);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: an operand slot that is filled by an accepted request
   // and emptied when the consumer takes it.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int d = 0; d < 2; d++) begin
            m_valid[d] <= 1'b0;
            m_data[d]  <= 8'h00;
            m_err[d]   <= 1'b0;
            m_cnt[d]   <= 8'h00;
         end
      end else begin
         for (int d = 0; d < 2; d++) begin
            int  n;
            bit  room, take, give, bad;
            n    = (d == 0) ? 8 : 6;
            room = !m_valid[d] || out_ready;
            take = in_valid && !hold && room;
            give = m_valid[d] && out_ready && !hold;
            bad  = take && (int'(sel) >= n);
            if (take) begin
               m_valid[d] <= 1'b1;
               m_data[d]  <= pick(n, int'(sel));
               m_cnt[d]   <= 8'((int'(m_cnt[d]) + 1) % 256);
            end else if (give) begin
               m_valid[d] <= 1'b0;
            end
            if (bad) m_err[d] <= 1'b1;
            else if (err_clr) m_err[d] <= 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         check("dut8 out_valid", 32'(out_valid8), 32'(m_valid[0]));
         check("dut8 out_data",  32'(out_data8),  32'(m_data[0]));
         check("dut8 sel_err",   32'(sel_err8),   32'(m_err[0]));
         check("dut8 accept_cnt",32'(cnt8),       32'(m_cnt[0]));
         check("dut8 in_ready",  32'(in_ready8),  32'(!hold && (!m_valid[0] || out_ready)));
         check("dut6 out_valid", 32'(out_valid6), 32'(m_valid[1]));
         check("dut6 out_data",  32'(out_data6),  32'(m_data[1]));
         check("dut6 sel_err",   32'(sel_err6),   32'(m_err[1]));
         check("dut6 accept_cnt",32'(cnt6),       32'(m_cnt[1]));
         check("dut6 in_ready",  32'(in_ready6),  32'(!hold && (!m_valid[1] || out_ready)));
      end
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; hold = 1'b0; err_clr = 1'b0; sel = 3'd0;
      set_sources();
      tick();
      check("reset out_valid", 32'(out_valid8), 32'd0);
      check("reset out_data",  32'(out_data8),  32'd0);
      check("reset sel_err",   32'(sel_err6),   32'd0);
      check("reset cnt",       32'(cnt8),       32'd0);
      check("reset in_ready",  32'(in_ready8),  32'd1);
      rst_n = 1'b1;

      // single accept of source 5
      sel = 3'd5; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      check("first out_data",  32'(out_data8),  32'h15);
      check("first out_valid", 32'(out_valid8), 32'd1);
      check("first cnt",       32'(cnt8),       32'd1);

      // back-to-back accepts
      for (int i = 0; i < 3; i++) begin
         sel = 3'(i);
         tick();
         check("b2b out_data", 32'(out_data8), 32'h10 + 32'(i));
         check("b2b in_ready", 32'(in_ready8), 32'd1);
      end

      // stall with consumer not ready
      sel = 3'd3;
      tick();
      check("stall load", 32'(out_data8), 32'h13);
      out_ready = 1'b0;
      #1;
      check("stall in_ready", 32'(in_ready8), 32'd0);
      for (int i = 0; i < 4; i++) begin
         in_data = {$urandom(), $urandom()};
         tick();
         check("stall out_data", 32'(out_data8), 32'h13);
      end
      set_sources();
      sel = 3'd4; out_ready = 1'b1;
      #1;
      check("unstall in_ready", 32'(in_ready8), 32'd1);
      tick();
      check("drain+accept data", 32'(out_data8), 32'h14);
      check("drain+accept cnt",  32'(cnt8),      32'd6);

      // out-of-range select on the 6-source instance
      sel = 3'd7;
      tick();
      check("oor dut6 data",  32'(out_data6),  32'h00);
      check("oor dut6 valid", 32'(out_valid6), 32'd1);
      check("oor dut6 err",   32'(sel_err6),   32'd1);
      check("oor dut8 data",  32'(out_data8),  32'h17);
      check("oor dut8 err",   32'(sel_err8),   32'd0);
      in_valid = 1'b0; err_clr = 1'b1;
      tick();
      check("err_clr", 32'(sel_err6), 32'd0);
      err_clr = 1'b0; in_valid = 1'b1;
      tick();
      check("err reset", 32'(sel_err6), 32'd1);
      err_clr = 1'b1;
      tick();
      check("set beats clr", 32'(sel_err6), 32'd1);
      err_clr = 1'b0;

      // hold freezes the slot while err_clr still acts
      sel = 3'd1;
      tick();
      in_valid = 1'b0; hold = 1'b1; err_clr = 1'b1;
      #1;
      check("hold in_ready", 32'(in_ready8), 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         err_clr = 1'b0;
         check("hold out_valid", 32'(out_valid8), 32'd1);
         check("hold out_data",  32'(out_data8),  32'h11);
         check("hold cnt",       32'(cnt8),       32'd10);
      end
      check("hold err_clr", 32'(sel_err6), 32'd0);
      hold = 1'b0;
      tick();
      check("post-hold drain", 32'(out_valid8), 32'd0);

      // counter wrap
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1; in_valid = 1'b1; sel = 3'd2;
      repeat (255) tick();
      check("cnt 255", 32'(cnt8), 32'd255);
      tick();
      check("cnt wrap", 32'(cnt8), 32'd0);

      // asynchronous reset while FULL
      #2;
      rst_n = 1'b0;
      #1;
      check("async out_valid", 32'(out_valid8), 32'd0);
      check("async out_data",  32'(out_data8),  32'd0);
      check("async cnt",       32'(cnt8),       32'd0);
      tick();
      rst_n = 1'b1; sel = 3'd6;
      tick();
      check("post-reset data",  32'(out_data8),  32'h16);
      check("post-reset valid", 32'(out_valid8), 32'd1);
      check("post-reset cnt",   32'(cnt8),       32'd1);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         in_data   = {$urandom(), $urandom()};
         sel       = 3'($urandom_range(0, 7));
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         hold      = ($urandom_range(0, 4) == 0);
         err_clr   = ($urandom_range(0, 7) == 0);
         tick();
      end
      in_valid = 1'b0; hold = 1'b0; err_clr = 1'b0;
      tick();
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
